// File: rtl/fp_div_pkg.sv
// -----------------------------------------------------------------------------
// fp_div_pkg
// Shared constants and FSM state type for the sequential FP significand
// divider (fp_mant_div_seq) and its combinational step cell (fp_div_step).
//   MANT_W : significand width including the hidden bit
//   Q_W    : quotient bits produced (1 integer + 23 fraction + guard + round)
//   REM_W  : partial remainder width (one headroom bit above the significand)
//   CNT_W  : step counter width, wide enough to hold Q_W
// -----------------------------------------------------------------------------
package fp_div_pkg;

   localparam int MANT_W = 24;
   localparam int Q_W    = 26;
   localparam int REM_W  = MANT_W + 1;
   localparam int CNT_W  = $clog2(Q_W + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/fp_div_step.sv
// -----------------------------------------------------------------------------
// fp_div_step
// One restoring-division step, purely combinational.
// Ports:
//   i_rem      : current partial remainder (REM_W bits)
//   i_divisor  : divisor significand (MANT_W bits)
//   o_q        : quotient bit, 1 when i_rem >= i_divisor (equality counts)
//   o_rem_next : (o_q ? i_rem - i_divisor : i_rem) << 1, truncated to REM_W
// -----------------------------------------------------------------------------
module fp_div_step
   import fp_div_pkg::*;
(
   input  logic [REM_W-1:0]  i_rem,
   input  logic [MANT_W-1:0] i_divisor,
   output logic              o_q,
   output logic [REM_W-1:0]  o_rem_next
);

   logic [REM_W-1:0] w_div_ext;
   logic [REM_W-1:0] w_diff;

   assign w_div_ext = {1'b0, i_divisor};
   assign o_q       = (i_rem >= w_div_ext);
   assign w_diff    = o_q ? (i_rem - w_div_ext) : i_rem;
   // After a subtraction the remainder is below the divisor, so the top bit
   // of w_diff is always clear and the shift loses nothing.
   assign o_rem_next = {w_diff[REM_W-2:0], 1'b0};

endmodule

// File: rtl/fp_mant_div_seq.sv
// -----------------------------------------------------------------------------
// fp_mant_div_seq
// Iterative restoring divider for single-precision significands, one quotient
// bit per clock. Sits between operand unpack and normalise/round; never
// normalises its own result (quotient MSB = integer bit).
// Ports:
//   in_clk          : clock, all state on rising edge
//   in_rst_n        : synchronous active-low reset
//   in_start        : start request, only honoured when not busy
//   in_flush        : abort; wins over in_start, cancels a running op
//   in_dividend     : dividend significand (hidden bit set)
//   in_divisor      : divisor significand (hidden bit set, or zero)
//   out_busy        : high while iterating
//   out_valid       : one-cycle completion pulse
//   out_quotient    : Q_W-bit quotient, held until the next accepted start
//   out_sticky      : OR of final remainder, held like the quotient
//   out_div_by_zero : divisor was zero, held like the quotient
// Build option:
//   FP_DIV_EARLY_EXIT_EN : when defined, finish as soon as the remainder
//                          becomes zero, zero-filling the remaining quotient
//                          bits. Undefined gives a fixed Q_W-step latency.
// -----------------------------------------------------------------------------
module fp_mant_div_seq
   import fp_div_pkg::*;
(
   input  logic              in_clk,
   input  logic              in_rst_n,
   input  logic              in_start,
   input  logic              in_flush,
   input  logic [MANT_W-1:0] in_dividend,
   input  logic [MANT_W-1:0] in_divisor,
   output logic              out_busy,
   output logic              out_valid,
   output logic [Q_W-1:0]    out_quotient,
   output logic              out_sticky,
   output logic              out_div_by_zero
);

   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(Q_W);

   div_state_e        r_state;
   logic [REM_W-1:0]  r_rem;
   logic [MANT_W-1:0] r_div;
   logic [Q_W-1:0]    r_quot;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_sticky;
   logic              r_dbz;

   logic              w_q;
   logic [REM_W-1:0]  w_rem_next;
   logic [Q_W-1:0]    w_quot_next;
   logic [CNT_W-1:0]  w_cnt_next;

   fp_div_step u_step (
      .i_rem      (r_rem),
      .i_divisor  (r_div),
      .o_q        (w_q),
      .o_rem_next (w_rem_next)
   );

   assign w_quot_next = {r_quot[Q_W-2:0], w_q};
   assign w_cnt_next  = r_cnt + CNT_W'(1);

`ifdef FP_DIV_EARLY_EXIT_EN
   logic [CNT_W-1:0] w_steps_left;
   logic [Q_W-1:0]   w_quot_early;

   // Remaining quotient bits are all zero once the remainder vanishes, so the
   // partial quotient is simply shifted into its final position.
   assign w_steps_left = LP_LAST - w_cnt_next;
   assign w_quot_early = w_quot_next << w_steps_left;
`endif

   always_ff @(posedge in_clk) begin
      if (!in_rst_n) begin
         r_state  <= ST_IDLE;
         r_rem    <= '0;
         r_div    <= '0;
         r_quot   <= '0;
         r_cnt    <= '0;
         r_sticky <= 1'b0;
         r_dbz    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (in_flush) begin
                  r_state <= ST_IDLE;
               end else if (in_start) begin
                  r_rem <= {1'b0, in_dividend};
                  r_div <= in_divisor;
                  r_cnt <= '0;
                  if (in_divisor == '0) begin
                     // Divide by zero bypasses iteration entirely.
                     r_state  <= ST_DONE;
                     r_quot   <= '1;
                     r_sticky <= 1'b1;
                     r_dbz    <= 1'b1;
                  end else begin
                     r_state  <= ST_RUN;
                     r_quot   <= '0;
                     r_sticky <= 1'b0;
                     r_dbz    <= 1'b0;
                  end
               end else begin
                  r_state <= ST_IDLE;
               end
            end

            ST_RUN: begin
               if (in_flush) begin
                  r_state  <= ST_IDLE;
                  r_rem    <= '0;
                  r_quot   <= '0;
                  r_cnt    <= '0;
                  r_sticky <= 1'b0;
                  r_dbz    <= 1'b0;
               end else begin
                  r_rem <= w_rem_next;
                  r_cnt <= w_cnt_next;
                  if (w_cnt_next == LP_LAST) begin
                     r_state  <= ST_DONE;
                     r_quot   <= w_quot_next;
                     r_sticky <= |w_rem_next;
`ifdef FP_DIV_EARLY_EXIT_EN
                  end else if (w_rem_next == '0) begin
                     r_state  <= ST_DONE;
                     r_quot   <= w_quot_early;
                     r_sticky <= 1'b0;
`endif
                  end else begin
                     r_quot <= w_quot_next;
                  end
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign out_busy        = (r_state == ST_RUN);
   assign out_valid       = (r_state == ST_DONE);
   assign out_quotient    = r_quot;
   assign out_sticky      = r_sticky;
   assign out_div_by_zero = r_dbz;

endmodule

// File: tb/tb_fp_mant_div_seq.sv
// -----------------------------------------------------------------------------
// tb_fp_mant_div_seq
// Self-checking bench for fp_mant_div_seq: directed cases, flush, reset during
// an operation, back-to-back starts and randomized normalised operands, all
// compared against an arithmetic reference (scaled integer division).
// -----------------------------------------------------------------------------
module tb_fp_mant_div_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        flush;
   logic [23:0] dvd;
   logic [23:0] dvs;
   logic        busy;
   logic        valid;
   logic [25:0] quot;
   logic        sticky;
   logic        dbz;

   int n_chk = 0;
   int n_err = 0;

   fp_mant_div_seq dut (
      .in_clk          (clk),
      .in_rst_n        (rst_n),
      .in_start        (start),
      .in_flush        (flush),
      .in_dividend     (dvd),
      .in_divisor      (dvs),
      .out_busy        (busy),
      .out_valid       (valid),
      .out_quotient    (quot),
      .out_sticky      (sticky),
      .out_div_by_zero (dbz)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: quotient = floor(a * 2^25 / b), sticky = nonzero remainder.
   function automatic void ref_div(input logic [23:0] a, input logic [23:0] b,
                                   output logic [25:0] q, output logic s,
                                   output logic z);
      longint n;
      if (b == 24'd0) begin
         q = '1;
         s = 1'b1;
         z = 1'b1;
      end else begin
         n = longint'(a) << 25;
         q = 26'(n / longint'(b));
         s = ((n % longint'(b)) != 0);
         z = 1'b0;
      end
   endfunction

   function automatic logic [23:0] rnd_norm();
      return 24'h800000 | 24'($urandom & 32'h007F_FFFF);
   endfunction

   // Drives a start for one cycle; returns one cycle after the accepting edge.
   task automatic start_op(input logic [23:0] a, input logic [23:0] b);
      dvd   = a;
      dvs   = b;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Waits (bounded) for out_valid; optionally pulses an ignored start at
   // cycle ign_at. Returns in the DONE cycle.
   task automatic wait_done(input string tag, input logic [23:0] a,
                            input logic [23:0] b, input int ign_at);
      logic [25:0] eq;
      logic        es;
      logic        ez;
      int          cyc;
      ref_div(a, b, eq, es, ez);
      cyc = 1;
      if (b != 24'd0) chk({tag, "_busy"}, 64'(busy), 64'd1);
      while (!valid && cyc < 60) begin
         if (cyc == ign_at) begin
            dvd   = 24'($urandom);
            dvs   = 24'($urandom);
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         tick();
         cyc++;
      end
      start = 1'b0;
      chk({tag, "_valid"}, 64'(valid), 64'd1);
`ifndef FP_DIV_EARLY_EXIT_EN
      chk({tag, "_lat"}, 64'(cyc), (b == 24'd0) ? 64'd1 : 64'd27);
`endif
      chk({tag, "_quot"},   64'(quot),   64'(eq));
      chk({tag, "_sticky"}, 64'(sticky), 64'(es));
      chk({tag, "_dbz"},    64'(dbz),    64'(ez));
      chk({tag, "_nobusy"}, 64'(busy),   64'd0);
   endtask

   // One cycle past DONE: pulse gone, results held.
   task automatic post_done(input string tag, input logic [23:0] a, input logic [23:0] b);
      logic [25:0] eq;
      logic        es;
      logic        ez;
      ref_div(a, b, eq, es, ez);
      tick();
      chk({tag, "_pulse"}, 64'(valid), 64'd0);
      chk({tag, "_hold"},  64'(quot),  64'(eq));
   endtask

   initial begin
      logic [23:0] a;
      logic [23:0] b;
      int          extra;

      rst_n = 1'b0;
      start = 1'b0;
      flush = 1'b0;
      dvd   = '0;
      dvs   = '0;
      repeat (3) tick();
      chk("rst_busy",   64'(busy),   64'd0);
      chk("rst_valid",  64'(valid),  64'd0);
      chk("rst_quot",   64'(quot),   64'd0);
      chk("rst_sticky", 64'(sticky), 64'd0);
      chk("rst_dbz",    64'(dbz),    64'd0);
      rst_n = 1'b1;
      tick();

      // Directed values
      start_op(24'h800000, 24'h800000);
      wait_done("one_one", 24'h800000, 24'h800000, -1);
      chk("one_one_exact", 64'(quot), 64'h2000000);
      post_done("one_one", 24'h800000, 24'h800000);

      start_op(24'hC00000, 24'h800000);
      wait_done("c_over_8", 24'hC00000, 24'h800000, -1);
      chk("c_over_8_exact", 64'(quot), 64'h3000000);
      post_done("c_over_8", 24'hC00000, 24'h800000);

      start_op(24'h800000, 24'hC00000);
      wait_done("8_over_c", 24'h800000, 24'hC00000, -1);
      chk("8_over_c_exact", 64'(quot), 64'h1555555);
      chk("8_over_c_stk",   64'(sticky), 64'd1);
      post_done("8_over_c", 24'h800000, 24'hC00000);

      start_op(24'hABCDEF, 24'h000000);
      wait_done("dbz", 24'hABCDEF, 24'h000000, -1);
      chk("dbz_exact", 64'(quot), 64'h3FFFFFF);
      post_done("dbz", 24'hABCDEF, 24'h000000);

      // Start pulse in RUN must be ignored
      start_op(24'h900000, 24'hF00000);
      wait_done("ign", 24'h900000, 24'hF00000, 5);
      extra = 0;
      repeat (35) begin
         tick();
         if (valid) extra++;
      end
      chk("ign_no_extra_valid", 64'(extra), 64'd0);

      // Flush at cycle 10, restart at cycle 12
      start_op(24'hC00000, 24'h900000);
      repeat (9) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_busy",  64'(busy),  64'd0);
      chk("flush_valid", 64'(valid), 64'd0);
      chk("flush_quot",  64'(quot),  64'd0);
      tick();
      chk("flush_valid2", 64'(valid), 64'd0);
      start_op(24'hF00000, 24'hA00000);
      wait_done("after_flush", 24'hF00000, 24'hA00000, -1);
      post_done("after_flush", 24'hF00000, 24'hA00000);

      // Start and flush together: flush wins
      dvd   = 24'h800000;
      dvs   = 24'h800000;
      start = 1'b1;
      flush = 1'b1;
      tick();
      start = 1'b0;
      flush = 1'b0;
      chk("sf_busy",  64'(busy),  64'd0);
      chk("sf_valid", 64'(valid), 64'd0);

      // Back-to-back: second start in the DONE cycle
      start_op(24'hE00000, 24'hB00000);
      wait_done("b2b_a", 24'hE00000, 24'hB00000, -1);
      start_op(24'h812345, 24'hFEDCBA);
      wait_done("b2b_b", 24'h812345, 24'hFEDCBA, -1);
      post_done("b2b_b", 24'h812345, 24'hFEDCBA);

      // Randomized normalised operands, chained back-to-back
      a = rnd_norm();
      b = rnd_norm();
      start_op(a, b);
      for (int i = 0; i < 10; i++) begin
         wait_done("rnd", a, b, (i % 3 == 0) ? 7 : -1);
         a = rnd_norm();
         b = (i == 4) ? 24'd0 : rnd_norm();
         start_op(a, b);
      end
      wait_done("rnd_last", a, b, -1);
      post_done("rnd_last", a, b);

      // Reset in the middle of an operation
      start_op(24'hC00000, 24'hD00000);
      repeat (5) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mid_rst_busy",   64'(busy),   64'd0);
      chk("mid_rst_valid",  64'(valid),  64'd0);
      chk("mid_rst_quot",   64'(quot),   64'd0);
      chk("mid_rst_sticky", 64'(sticky), 64'd0);
      tick();
      chk("mid_rst_valid2", 64'(valid), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/fp_mant_div_seq.md
Name: fp_mant_div_seq

Overview:
- Iterative restoring divider for FP single-precision significands; retires one quotient bit per clock.
- Sits between FP_Div operand unpack and normalise/round: takes 24-bit significands (hidden bit set) and returns quotient, guard/round bits and sticky.
- Instantiates one combinational step cell per cycle; holds remainder, quotient and control state.

Parameters:
- MANT_W, 24, significand width including hidden bit
- Q_W, 26, quotient bits produced: 1 integer + 23 fraction + guard + round

Ports:
- in_clk  input  1  clock, all state on rising edge
- in_rst_n  input  1  reset, synchronous, active-low
- in_start  input  1  start request; sampled only when not busy
- in_flush  input  1  abort current operation
- in_dividend  input  MANT_W  dividend significand
- in_divisor  input  MANT_W  divisor significand
- out_busy  output  1  high while iterating
- out_valid  output  1  one-cycle completion pulse
- out_quotient  output  Q_W  quotient; MSB = integer bit
- out_sticky  output  1  OR of final remainder
- out_div_by_zero  output  1  divisor was zero

Behaviour:
- Reset: when in_rst_n low at an edge, state=IDLE; all outputs, remainder, quotient and counter are 0.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE + in_start=1: load rem = {1'b0, in_dividend} (MANT_W+1 bits), latch divisor, clear quotient and counter, go to RUN. In_start with in_flush=1 in the same cycle: flush wins, go to IDLE.
- Divisor = 0 at start: skip RUN and go to DONE. Quotient = all ones, sticky = 1, out_div_by_zero = 1.
- RUN step, each edge:
  - q = (rem >= divisor), using unsigned compare; equality counts as 1.
  - rem_next = (q ? rem - divisor : rem) << 1, truncated to MANT_W+1 bits.
  - quotient = {quotient[Q_W-2:0], q}; counter increments.
- After Q_W steps, go to DONE.
- DONE is one cycle: out_valid = 1. out_sticky = |rem. Then go to IDLE unless in_start is restarted.
- Latency: in_start high in cycle 0 gives out_valid high in cycle Q_W+1 (cycle 27 at defaults).
- out_busy = 1 in RUN only. Back-to-back operation is legal: a start accepted in the DONE cycle begins the next op.
- out_quotient, out_sticky and out_div_by_zero hold their values after DONE until the next accepted start. They clear on load.
- in_start in RUN is ignored, with no queuing.
- in_flush in RUN: go to IDLE next edge, no out_valid, outputs cleared.
- Reset in RUN: same as flush, plus all registers are zeroed.
- Operand range: both inputs in [2^23, 2^24) gives a quotient in (0.5, 2). Quotient MSB = 0 means downstream left-shifts by 1; this block never normalises.

Optional Feature:
- Macro: FP_DIV_EARLY_EXIT_EN.
- Defined: in RUN, if rem_next == 0 after a step, go directly to DONE. Quotient is left-shifted by the remaining step count (zero fill); sticky = 0. Latency is variable, minimum 2 cycles after start.
- Undefined: fixed Q_W-step latency always; no zero detection logic.

Decomposition:
- Package fp_div_pkg: MANT_W and Q_W constants, FSM state enum, counter width as clog2(Q_W+1).
- Sub-module: fp_div_step, purely combinational.
  - Inputs: rem (MANT_W+1), divisor (MANT_W).
  - Outputs: q bit, next rem; uses >= compare.
  - Instantiated once; the FSM and registers live in the top.

Test Plan:
- 1.0/1.0: dividend 24'h800000, divisor 24'h800000, start at cycle 0 -> valid at cycle 27, quotient 26'h2000000, sticky 0.
- 1.5/1.0: 24'hC00000 / 24'h800000 -> quotient 26'h3000000, sticky 0.
- 1.0/1.5: 24'h800000 / 24'hC00000 -> quotient 26'h1555555, sticky 1.
- Divisor 0: any dividend -> valid 1 cycle after start, quotient 26'h3FFFFFF, div_by_zero 1.
- Flush at cycle 10 of an op -> no valid pulse, busy low next cycle. A start at cycle 12 completes normally at cycle 39.
- Back-to-back: second start asserted in the DONE cycle -> second valid exactly 27 cycles later. Start pulses during RUN are ignored and produce no extra valid.
